// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and a saturating bubble counter.
// Latency: one cycle from *_id inputs to *_ex outputs; load_use and stall_id are combinational.
// Backpressure: hold_ex freezes everything; a load-use hazard inserts one bubble and raises stall_id.
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] rs1Data_id,
    input  logic [XLEN-1:0] rs2Data_id,
    input  logic [XLEN-1:0] imm_id,
    input  logic [XLEN-1:0] pc_id,
    input  logic [4:0]      rs1Addr,
    input  logic [4:0]      rs2Addr,
    input  logic [4:0]      rdAddr_id,
    input  logic            use_rs1_id,
    input  logic            use_rs2_id,
    input  logic            valid_id,
    input  logic            RegWrite_id,
    input  logic            MemRead_id,
    input  logic            MemWrite_id,
    input  logic            MemtoReg_id,
    input  logic            ALUSrc_id,
    input  logic [3:0]      ALUOp_id,
    input  logic            flush_ex,
    input  logic            hold_ex,
    output logic [XLEN-1:0] rs1Data_ex,
    output logic [XLEN-1:0] rs2Data_ex,
    output logic [XLEN-1:0] imm_ex,
    output logic [XLEN-1:0] pc_ex,
    output logic [4:0]      rs1Addr_ex,
    output logic [4:0]      rs2Addr_ex,
    output logic [4:0]      rdAddr_ex,
    output logic            valid_ex,
    output logic            RegWrite_ex,
    output logic            MemRead_ex,
    output logic            MemWrite_ex,
    output logic            MemtoReg_ex,
    output logic            ALUSrc_ex,
    output logic [3:0]      ALUOp_ex,
    output logic            stall_id,
    output logic [15:0]     bubble_cnt
);

    // Everything the EX stage sees about one instruction, kept as one register.
    typedef struct packed {
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [4:0]      rd_addr;
        logic            valid;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
        logic            alu_src;
        logic [3:0]      alu_op;
    } ex_t;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    ex_t         ex_q;
    ex_t         ex_d;
    ex_t         id_pkt;
    logic [15:0] bubble_cnt_q;
    logic [15:0] bubble_cnt_d;
    logic        load_use;
    logic        rs1_hit;
    logic        rs2_hit;

    // Hazard: a valid load in EX writes a register (not x0) that the ID instruction actually reads.
    always_comb begin
        rs1_hit  = use_rs1_id && (rs1Addr == ex_q.rd_addr);
        rs2_hit  = use_rs2_id && (rs2Addr == ex_q.rd_addr);
        load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd_addr != 5'd0) &&
                   valid_id && (rs1_hit || rs2_hit);
        stall_id = load_use || hold_ex;
    end

    // Package the ID inputs; an invalid slot must never write the register file or memory.
    always_comb begin
        id_pkt            = '0;
        id_pkt.rs1_data   = rs1Data_id;
        id_pkt.rs2_data   = rs2Data_id;
        id_pkt.imm        = imm_id;
        id_pkt.pc         = pc_id;
        id_pkt.rs1_addr   = rs1Addr;
        id_pkt.rs2_addr   = rs2Addr;
        id_pkt.rd_addr    = rdAddr_id;
        id_pkt.valid      = valid_id;
        id_pkt.reg_write  = valid_id && RegWrite_id;
        id_pkt.mem_read   = valid_id && MemRead_id;
        id_pkt.mem_write  = valid_id && MemWrite_id;
        id_pkt.mem_to_reg = MemtoReg_id;
        id_pkt.alu_src    = ALUSrc_id;
        id_pkt.alu_op     = ALUOp_id;
    end

    // Next-state selection: hold > flush > load-use bubble > capture (reset handled in the flop).
    always_comb begin
        ex_d         = ex_q;
        bubble_cnt_d = bubble_cnt_q;
        if (hold_ex) begin
            ex_d = ex_q;
        end else if (flush_ex) begin
            ex_d = '0;
        end else if (load_use) begin
            ex_d = '0;
            if (bubble_cnt_q != CNT_MAX) begin
                bubble_cnt_d = bubble_cnt_q + 16'd1;
            end
        end else begin
            ex_d = id_pkt;
        end
    end

    // State registers with synchronous active-low reset overriding every other action.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q         <= '0;
            bubble_cnt_q <= '0;
        end else begin
            ex_q         <= ex_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign rs1Data_ex  = ex_q.rs1_data;
    assign rs2Data_ex  = ex_q.rs2_data;
    assign imm_ex      = ex_q.imm;
    assign pc_ex       = ex_q.pc;
    assign rs1Addr_ex  = ex_q.rs1_addr;
    assign rs2Addr_ex  = ex_q.rs2_addr;
    assign rdAddr_ex   = ex_q.rd_addr;
    assign valid_ex    = ex_q.valid;
    assign RegWrite_ex = ex_q.reg_write;
    assign MemRead_ex  = ex_q.mem_read;
    assign MemWrite_ex = ex_q.mem_write;
    assign MemtoReg_ex = ex_q.mem_to_reg;
    assign ALUSrc_ex   = ex_q.alu_src;
    assign ALUOp_ex    = ex_q.alu_op;
    assign bubble_cnt  = bubble_cnt_q;

endmodule
